lcd_bus_writer: RTL and testbench
=================================

// Module: lcd_bus_writer
// PURPOSE
//   Downstream stage of the LCD data-out mux. Accepts one selected byte per write
//   request and drives it onto the HD44780-style parallel bus (data, RS, RW, E).
//   Enforces the setup, enable-high and hold times and the controller execution
//   delay, then signals completion. Lets the setup sequencer and char generator
//   pace their writes on busy/done instead of fixed delays.
// PARAMETERS
//   SETUP_CYC     4       clocks data/RS are stable before E rises (>=1)
//   E_HIGH_CYC    50      clocks E is held high (>=1)
//   HOLD_CYC      2       clocks data/RS are held after E falls (>=1)
//   CMD_WAIT_CYC  4000    execution wait for normal commands/data (>=1), ~40us @100MHz
//   CLR_WAIT_CYC  164000  execution wait for clear/home commands (>=1), ~1.64ms
//   CNT_W         18      counter width; must hold max(all *_CYC)
// PORTS
//   clk      in   1  system clock, rising edge
//   resetN   in   1  asynchronous active-low reset
//   dIn      in   8  byte to write (the mux's final data output)
//   rsIn     in   1  register select for this byte: 0 = command, 1 = data
//   wrReq    in   1  write request, sampled on rising clk
//   wrBusy   out  1  high from acceptance until completion
//   wrDone   out  1  one-cycle pulse when the write and execution wait finish
//   lcdData  out  8  LCD data bus
//   lcdRs    out  1  LCD register select
//   lcdRw    out  1  LCD read/write; always 0 (write only)
//   lcdE     out  1  LCD enable strobe
// BEHAVIOUR
//   - All outputs are registered. Reset (async, resetN=0) forces: state=IDLE,
//     counter=0, wrBusy=0, wrDone=0, lcdE=0, lcdRs=0, lcdRw=0, lcdData=8'h00.
//   - FSM states: IDLE -> SETUP -> EHIGH -> HOLD -> WAIT -> IDLE.
//   - IDLE: if wrReq=1 at edge t0, latch dIn into lcdData and rsIn into lcdRs,
//     set wrBusy=1 and go to SETUP. wrReq=0 keeps the FSM idle with outputs unchanged.
//   - SETUP: lasts SETUP_CYC clocks with E=0. lcdE rises at edge t0+SETUP_CYC.
//   - EHIGH: lasts E_HIGH_CYC clocks. lcdE falls at t0+SETUP_CYC+E_HIGH_CYC.
//   - HOLD: lasts HOLD_CYC clocks with E=0 and data/RS unchanged.
//   - WAIT: lasts W clocks. W=CLR_WAIT_CYC when the latched rs=0 and the latched
//     byte is 8'h01, 8'h02 or 8'h03 (clear/home); otherwise W=CMD_WAIT_CYC.
//   - Completion: at edge t0+S+E+H+W the FSM returns to IDLE, wrBusy=0 and
//     wrDone=1 for exactly one cycle.
//   - Back-to-back: wrReq high in the wrDone cycle is accepted at the next edge,
//     giving a minimum of 1 idle cycle between writes.
//   - wrReq while wrBusy=1 is ignored; it is not queued. dIn/rsIn are don't-care
//     after acceptance.
//   - lcdData/lcdRs keep the last written value after completion; they change
//     only on acceptance or reset.
//   - A single down-counter is reloaded on each state entry with (N-1) and
//     advances the state at 0. No state ever lasts 0 clocks.
//   - Reset mid-write drops lcdE immediately (async) and aborts the write. No
//     wrDone is produced for an aborted write.
//   - lcdE high is only possible in EHIGH.
// TESTING
//   1 reset: hold resetN=0 with random inputs -> all outputs 0, wrBusy=0; release,
//     no wrReq for 100 cycles -> outputs remain 0.
//   2 data write: dIn=8'h41, rsIn=1, wrReq pulse at t0 -> lcdData=41, lcdRs=1 at
//     t0+1; lcdE high exactly over [t0+4, t0+54); wrDone single pulse at t0+4056.
//   3 clear command: dIn=8'h01, rsIn=0 -> same E timing, wrDone at t0+164056;
//     repeat with 8'h38, rsIn=0 -> wrDone at t0+4056.
//   4 request while busy: second wrReq with dIn=8'h55 at t0+10 -> ignored;
//     lcdData stays 41, exactly one E pulse and one wrDone.
//   5 back-to-back: wrReq held high with dIn 8'h48 then 8'h49 -> second
//     acceptance on the edge after wrDone; data stable throughout each E-high window.
//   6 reset mid-write: resetN low during EHIGH -> lcdE=0 immediately, no wrDone;
//     a write after release times correctly.

Source files
------------

// File: rtl/lcd_bus_writer.sv
// HD44780-style parallel bus writer: latches one byte per request, sequences
// setup / E-high / hold / controller execution wait, then pulses wrDone.
module lcd_bus_writer #(
  parameter int SETUP_CYC    = 4,
  parameter int E_HIGH_CYC   = 50,
  parameter int HOLD_CYC     = 2,
  parameter int CMD_WAIT_CYC = 4000,
  parameter int CLR_WAIT_CYC = 164000,
  parameter int CNT_W        = 18
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] dIn,
  input  logic       rsIn,
  input  logic       wrReq,
  output logic       wrBusy,
  output logic       wrDone,
  output logic [7:0] lcdData,
  output logic       lcdRs,
  output logic       lcdRw,
  output logic       lcdE
);

  typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, WAIT} state_t;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EHIGH_LD = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [7:0]       dataNext;
  logic             rsNext, eNext, busyNext, doneNext;
  logic             isClr;

  // Clear-display and return-home commands need the long execution wait.
  assign isClr = !lcdRs && (lcdData == 8'h01 || lcdData == 8'h02 || lcdData == 8'h03);

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    dataNext  = lcdData;
    rsNext    = lcdRs;
    eNext     = 1'b0;
    busyNext  = wrBusy;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if (wrReq) begin
          dataNext  = dIn;
          rsNext    = rsIn;
          busyNext  = 1'b1;
          cntNext   = SETUP_LD;
          stateNext = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          eNext     = 1'b1;
          cntNext   = EHIGH_LD;
          stateNext = EHIGH;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      EHIGH: begin
        if (cnt == '0) begin
          cntNext   = HOLD_LD;
          stateNext = HOLD;
        end else begin
          eNext   = 1'b1;
          cntNext = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          cntNext   = isClr ? CLR_LD : CMD_LD;
          stateNext = WAIT;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          busyNext  = 1'b0;
          doneNext  = 1'b1;
          stateNext = IDLE;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      default: begin
        busyNext  = 1'b0;
        cntNext   = '0;
        stateNext = IDLE;
      end
    endcase
  end

  // All bus and handshake outputs are registered straight from the next-state logic.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      cnt     <= '0;
      wrBusy  <= 1'b0;
      wrDone  <= 1'b0;
      lcdData <= 8'h00;
      lcdRs   <= 1'b0;
      lcdRw   <= 1'b0;
      lcdE    <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      wrBusy  <= busyNext;
      wrDone  <= doneNext;
      lcdData <= dataNext;
      lcdRs   <= rsNext;
      lcdRw   <= 1'b0;
      lcdE    <= eNext;
    end
  end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed bench for lcd_bus_writer; execution waits are shortened so the
// clear-command path stays within a short run while E timing is unchanged.
module tb_lcd_bus_writer;

  localparam int S_C   = 4;
  localparam int E_C   = 50;
  localparam int H_C   = 2;
  localparam int CMD_C = 40;
  localparam int CLR_C = 400;
  localparam int TOT_CMD = S_C + E_C + H_C + CMD_C;
  localparam int TOT_CLR = S_C + E_C + H_C + CLR_C;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] dIn = 8'h00;
  logic       rsIn = 1'b0;
  logic       wrReq = 1'b0;
  logic       wrBusy, wrDone, lcdRs, lcdRw, lcdE;
  logic [7:0] lcdData;

  int compared = 0;
  int mismatched = 0;

  lcd_bus_writer #(
    .SETUP_CYC(S_C), .E_HIGH_CYC(E_C), .HOLD_CYC(H_C),
    .CMD_WAIT_CYC(CMD_C), .CLR_WAIT_CYC(CLR_C), .CNT_W(18)
  ) dut (
    .clk(clk), .resetN(resetN), .dIn(dIn), .rsIn(rsIn), .wrReq(wrReq),
    .wrBusy(wrBusy), .wrDone(wrDone), .lcdData(lcdData), .lcdRs(lcdRs),
    .lcdRw(lcdRw), .lcdE(lcdE)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed observation: {lcdE, wrBusy, wrDone, lcdRw, lcdRs, lcdData}
  task automatic test_reset();
    logic [12:0] obs;
    resetN = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dIn = 8'($urandom); rsIn = 1'($urandom); wrReq = 1'($urandom);
      tick();
      obs = {lcdE, wrBusy, wrDone, lcdRw, lcdRs, lcdData};
      compared++;
      if (obs !== 13'h0) begin
        mismatched++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs, 13'h0);
      end
    end
    wrReq = 1'b0; dIn = 8'hFF; rsIn = 1'b1;
    resetN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      obs = {lcdE, wrBusy, wrDone, lcdRw, lcdRs, lcdData};
      compared++;
      if (obs !== 13'h0) begin
        mismatched++;
        $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs, 13'h0);
      end
    end
  endtask

  task automatic test_data_write();
    logic [12:0] obs, exp;
    dIn = 8'h41; rsIn = 1'b1; wrReq = 1'b1;
    tick();
    wrReq = 1'b0; dIn = 8'hA5; rsIn = 1'b0;
    for (int k = 0; k <= TOT_CMD + 3; k++) begin
      if (k > 0) tick();
      exp = {(k >= S_C && k < S_C + E_C), (k < TOT_CMD), (k == TOT_CMD), 1'b0, 1'b1, 8'h41};
      obs = {lcdE, wrBusy, wrDone, lcdRw, lcdRs, lcdData};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL data_write k=%0d got=%h want=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_clear_cmd();
    logic [12:0] obs, exp;
    logic [7:0]  bytes [2];
    int          tots  [2];
    bytes[0] = 8'h01; tots[0] = TOT_CLR;
    bytes[1] = 8'h38; tots[1] = TOT_CMD;
    for (int w = 0; w < 2; w++) begin
      dIn = bytes[w]; rsIn = 1'b0; wrReq = 1'b1;
      tick();
      wrReq = 1'b0; dIn = 8'h00;
      for (int k = 0; k <= tots[w] + 3; k++) begin
        if (k > 0) tick();
        exp = {(k >= S_C && k < S_C + E_C), (k < tots[w]), (k == tots[w]), 1'b0, 1'b0, bytes[w]};
        obs = {lcdE, wrBusy, wrDone, lcdRw, lcdRs, lcdData};
        compared++;
        if (obs !== exp) begin
          mismatched++;
          $display("FAIL clear_cmd byte=%h k=%0d got=%h want=%h", bytes[w], k, obs, exp);
        end
      end
    end
  endtask

  task automatic test_busy_req();
    int   eRises = 0;
    int   dones = 0;
    logic ePrev = 1'b0;
    dIn = 8'h41; rsIn = 1'b1; wrReq = 1'b1;
    tick();
    wrReq = 1'b0;
    for (int k = 0; k <= TOT_CMD + 5; k++) begin
      if (k > 0) tick();
      if (k == 9) begin
        dIn = 8'h55; wrReq = 1'b1;
      end else begin
        wrReq = 1'b0;
      end
      if (lcdE && !ePrev) eRises++;
      ePrev = lcdE;
      if (wrDone) dones++;
      compared++;
      if (lcdData !== 8'h41) begin
        mismatched++;
        $display("FAIL busy_req_data k=%0d got=%h want=%h", k, lcdData, 8'h41);
      end
    end
    compared++;
    if (eRises !== 1) begin
      mismatched++;
      $display("FAIL busy_req_epulses got=%0d want=1", eRises);
    end
    compared++;
    if (dones !== 1) begin
      mismatched++;
      $display("FAIL busy_req_done got=%0d want=1", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] obs, exp;
    int          kk;
    logic [7:0]  d;
    dIn = 8'h48; rsIn = 1'b1; wrReq = 1'b1;
    tick();
    dIn = 8'h49;
    for (int k = 0; k <= 2 * TOT_CMD + 4; k++) begin
      if (k > 0) tick();
      if (k == TOT_CMD + 1) wrReq = 1'b0;
      if (k <= TOT_CMD) begin
        kk = k; d = 8'h48;
      end else begin
        kk = k - (TOT_CMD + 1); d = 8'h49;
      end
      exp = {(kk >= S_C && kk < S_C + E_C), (kk < TOT_CMD), (kk == TOT_CMD), 1'b0, 1'b1, d};
      obs = {lcdE, wrBusy, wrDone, lcdRw, lcdRs, lcdData};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL back_to_back k=%0d got=%h want=%h", k, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] obs, exp;
    int          dones = 0;
    dIn = 8'h30; rsIn = 1'b1; wrReq = 1'b1;
    tick();
    wrReq = 1'b0;
    for (int k = 1; k <= 20; k++) tick();
    compared++;
    if (lcdE !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_pre_e got=%b want=1", lcdE);
    end
    #2 resetN = 1'b0;
    #1;
    obs = {lcdE, wrBusy, wrDone, lcdRw, lcdRs, lcdData};
    compared++;
    if (obs !== 13'h0) begin
      mismatched++;
      $display("FAIL mid_async_reset got=%h want=%h", obs, 13'h0);
    end
    tick(); tick();
    #2 resetN = 1'b1;
    for (int k = 0; k < TOT_CMD + 10; k++) begin
      tick();
      if (wrDone) dones++;
    end
    compared++;
    if (dones !== 0) begin
      mismatched++;
      $display("FAIL mid_no_done got=%0d want=0", dones);
    end
    dIn = 8'h02; rsIn = 1'b0; wrReq = 1'b1;
    tick();
    wrReq = 1'b0;
    for (int k = 0; k <= TOT_CLR + 3; k++) begin
      if (k > 0) tick();
      exp = {(k >= S_C && k < S_C + E_C), (k < TOT_CLR), (k == TOT_CLR), 1'b0, 1'b0, 8'h02};
      obs = {lcdE, wrBusy, wrDone, lcdRw, lcdRs, lcdData};
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL mid_rewrite k=%0d got=%h want=%h", k, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_data_write();
    test_clear_cmd();
    test_busy_req();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
